// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with memory-ready stalls.
// Optional iterative multiply state enabled by defining MULTICYCLE_MULT_EN; otherwise mult traps as illegal.
module multicycle_control #(
   parameter int ALUOP_W     = 4,
   parameter int MULT_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               ir_write,
   output logic               mem_read,
   output logic               mem_write,
   output logic               i_or_d,
   output logic               reg_dst,
   output logic               reg_write,
   output logic               mem_to_reg,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         pc_source,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               mult_busy,
   output logic               illegal,
   output logic [3:0]         state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC_R   = 4'd6,
      R_WB     = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      MULT     = 4'd10,
      TRAP     = 4'd11
   } state_e;

   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_MULT = 4'b1000;
   localparam logic [3:0] ALU_XOR  = 4'b1101;
   localparam logic [3:0] ALU_NOR  = 4'b1100;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] FN_MULT  = 6'b011000;

   state_e state_q, state_d;
   logic [4:0] rDec;
   logic unusedZero;

   // The branch comparison happens in the datapath, so the zero flag is not consumed here.
   assign unusedZero = zero;

   // {legal, aluCode} for the R-type functs this unit executes in a single ALU pass.
   function automatic logic [4:0] rDecode(input logic [5:0] f);
      case (f)
         6'b100000: rDecode = {1'b1, ALU_ADD};
         6'b100010: rDecode = {1'b1, ALU_SUB};
         6'b100100: rDecode = {1'b1, ALU_AND};
         6'b100101: rDecode = {1'b1, ALU_OR};
         6'b101010: rDecode = {1'b1, ALU_SLT};
         6'b100110: rDecode = {1'b1, ALU_XOR};
         6'b100111: rDecode = {1'b1, ALU_NOR};
         default:   rDecode = 5'b0_0000;
      endcase
   endfunction

   assign rDec  = rDecode(funct);
   assign state = state_q;

`ifdef MULTICYCLE_MULT_EN
   logic [7:0] multCnt_q, multCnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         multCnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         multCnt_q <= multCnt_d;
      end
   end
`else
   localparam int unusedMultCycles = MULT_CYCLES;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end
`endif

   // Next-state and Moore output decode; only FETCH's PC/IR strobes follow mem_ready directly.
   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      alu_op        = '0;
      mult_busy     = 1'b0;
      illegal       = 1'b0;
`ifdef MULTICYCLE_MULT_EN
      multCnt_d     = multCnt_q;
`endif
      case (state_q)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            alu_op    = ALUOP_W'(ALU_ADD);
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            alu_op    = ALUOP_W'(ALU_ADD);
            case (opcode)
               OP_LW, OP_SW: state_d = MEM_ADDR;
               OP_RTYPE: begin
`ifdef MULTICYCLE_MULT_EN
                  if (funct == FN_MULT) begin
                     state_d   = MULT;
                     multCnt_d = 8'(MULT_CYCLES - 1);
                  end else
`endif
                  if (rDec[4]) state_d = EXEC_R;
                  else         state_d = TRAP;
               end
               OP_BEQ:  state_d = BRANCH;
               OP_J:    state_d = JUMP;
               default: state_d = TRAP;
            endcase
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = ALUOP_W'(ALU_ADD);
            state_d   = (opcode == OP_SW) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) state_d = MEM_WB;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = FETCH;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) state_d = FETCH;
         end
         EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_W'(rDec[3:0]);
            state_d   = R_WB;
         end
         R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = FETCH;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_W'(ALU_SUB);
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            state_d       = FETCH;
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            state_d   = FETCH;
         end
`ifdef MULTICYCLE_MULT_EN
         MULT: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_W'(ALU_MULT);
            mult_busy = 1'b1;
            if (multCnt_q == 8'd0) state_d = R_WB;
            else                   multCnt_d = multCnt_q - 8'd1;
         end
`endif
         TRAP: begin
            illegal = 1'b1;
            state_d = TRAP;
         end
         default: state_d = FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-instruction reference model queues the expected
// per-cycle control word and a negedge monitor compares it against the DUT.
module tb_multicycle_control;

   localparam int MC = 4;

   localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_RD = 3, S_MEM_WB = 4;
   localparam int S_MEM_WR = 5, S_EXEC_R = 6, S_R_WB = 7, S_BRANCH = 8, S_JUMP = 9;
   localparam int S_MULT = 10, S_TRAP = 11;

   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, FN_MULT = 6'b011000;

   logic       clk, rst_n, zero, mem_ready;
   logic [5:0] opcode, funct;
   logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
   logic       reg_dst, reg_write, mem_to_reg, alu_src_a, mult_busy, illegal;
   logic [1:0] alu_src_b, pc_source;
   logic [3:0] alu_op, state;
   logic [23:0] dutVec;

   int checks = 0;
   int passes = 0;
   int monIdx = 0;
   logic [23:0] sbQ[$];

   logic [5:0] rFuncts [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b101010, 6'b100110, 6'b100111};
   logic [3:0] rCodes  [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                               4'b0111, 4'b1101, 4'b1100};

   multicycle_control #(.ALUOP_W(4), .MULT_CYCLES(MC)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
      .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
      .alu_op(alu_op), .mult_busy(mult_busy), .illegal(illegal), .state(state)
   );

   assign dutVec = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, reg_dst,
                    reg_write, mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op,
                    mult_busy, illegal, state};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected control word for one cycle spent in state s, straight from the per-state output table.
   function automatic logic [23:0] expVec(input int s, input bit mr, input logic [3:0] rop);
      logic pcw, pwc, irw, mrd, mwr, iod, rdst, rw, m2r, sa, busy, ill;
      logic [1:0] sb, ps;
      logic [3:0] op;
      {pcw, pwc, irw, mrd, mwr, iod, rdst, rw, m2r, sa, busy, ill} = '0;
      sb = 2'b00; ps = 2'b00; op = 4'b0000;
      case (s)
         S_FETCH:    begin mrd = 1; sb = 2'b01; op = 4'b0010; pcw = mr; irw = mr; end
         S_DECODE:   begin sb = 2'b11; op = 4'b0010; end
         S_MEM_ADDR: begin sa = 1; sb = 2'b10; op = 4'b0010; end
         S_MEM_RD:   begin mrd = 1; iod = 1; end
         S_MEM_WB:   begin rw = 1; m2r = 1; end
         S_MEM_WR:   begin mwr = 1; iod = 1; end
         S_EXEC_R:   begin sa = 1; op = rop; end
         S_R_WB:     begin rw = 1; rdst = 1; end
         S_BRANCH:   begin sa = 1; op = 4'b0110; pwc = 1; ps = 2'b01; end
         S_JUMP:     begin pcw = 1; ps = 2'b10; end
         S_MULT:     begin sa = 1; op = 4'b1000; busy = 1; end
         S_TRAP:     begin ill = 1; end
         default:    ;
      endcase
      return {pcw, pwc, irw, mrd, mwr, iod, rdst, rw, m2r, sa, sb, ps, op, busy, ill, 4'(s)};
   endfunction

   task automatic checkOutput(input string name, input logic [23:0] got, input logic [23:0] exp);
      checks++;
      if (got !== exp) $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      else passes++;
   endtask

   // One clock of stimulus; the expected word for that cycle goes to the scoreboard.
   task automatic applyStimulus(input int s, input bit mr, input logic [3:0] rop);
      @(posedge clk);
      #1;
      mem_ready = mr;
      zero      = 1'($urandom);
      sbQ.push_back(expVec(s, mr, rop));
   endtask

   always @(negedge clk) begin
      if (sbQ.size() != 0) begin
         logic [23:0] e;
         e = sbQ.pop_front();
         checkOutput($sformatf("cycle%0d_state%0d", monIdx, e[3:0]), dutVec, e);
         monIdx++;
      end
   end

   // Reference sequencing of one instruction with chosen FETCH and memory stall counts.
   task automatic doInstr(input logic [5:0] op, input logic [5:0] fn, input int fStall, input int mStall);
      logic [3:0] rop;
      bit legalR;
      rop = 4'b0000;
      legalR = 0;
      for (int i = 0; i < 7; i++) if (rFuncts[i] == fn) begin rop = rCodes[i]; legalR = 1; end
      opcode = op;
      funct  = fn;
      repeat (fStall) applyStimulus(S_FETCH, 0, rop);
      applyStimulus(S_FETCH, 1, rop);
      applyStimulus(S_DECODE, 1'($urandom), rop);
      if (op == OP_LW) begin
         applyStimulus(S_MEM_ADDR, 1'($urandom), rop);
         repeat (mStall) applyStimulus(S_MEM_RD, 0, rop);
         applyStimulus(S_MEM_RD, 1, rop);
         applyStimulus(S_MEM_WB, 1'($urandom), rop);
      end else if (op == OP_SW) begin
         applyStimulus(S_MEM_ADDR, 1'($urandom), rop);
         repeat (mStall) applyStimulus(S_MEM_WR, 0, rop);
         applyStimulus(S_MEM_WR, 1, rop);
      end else if (op == OP_R && legalR) begin
         applyStimulus(S_EXEC_R, 1'($urandom), rop);
         applyStimulus(S_R_WB, 1'($urandom), rop);
`ifdef MULTICYCLE_MULT_EN
      end else if (op == OP_R && fn == FN_MULT) begin
         repeat (MC) applyStimulus(S_MULT, 1'($urandom), rop);
         applyStimulus(S_R_WB, 1'($urandom), rop);
`endif
      end else if (op == OP_BEQ) begin
         applyStimulus(S_BRANCH, 1'($urandom), rop);
      end else if (op == OP_J) begin
         applyStimulus(S_JUMP, 1'($urandom), rop);
      end else begin
         applyStimulus(S_TRAP, 1'($urandom), rop);
      end
   endtask

   // Asynchronous reset asserted mid-cycle, checked before the next clock edge.
   task automatic resetMid(input bit mr, input string name);
      @(posedge clk);
      #1 mem_ready = mr;
      #2 rst_n = 1'b0;
      #1 checkOutput(name, dutVec, expVec(S_FETCH, mr, 4'b0000));
      @(posedge clk);
      #1 checkOutput({name, "_hold"}, dutVec, expVec(S_FETCH, mr, 4'b0000));
      @(negedge clk);
      #1 mem_ready = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 6'd0; funct = 6'd0;
      #2 checkOutput("resetOutputsReadyLow", dutVec, expVec(S_FETCH, 0, 4'b0000));
      #10 mem_ready = 1'b1;
      #1 checkOutput("resetOutputsReadyHigh", dutVec, expVec(S_FETCH, 1, 4'b0000));
      @(negedge clk);
      #1 mem_ready = 1'b0;
      rst_n = 1'b1;

      doInstr(OP_LW, 6'd0, 0, 0);
      doInstr(OP_SW, 6'd0, 0, 2);
      doInstr(OP_R, 6'b100110, 1, 0);
      doInstr(OP_BEQ, 6'd0, 0, 0);
      doInstr(OP_J, 6'd0, 2, 0);
      doInstr(OP_R, FN_MULT, 0, 0);
`ifndef MULTICYCLE_MULT_EN
      resetMid(1'b1, "multTrapReset");
`endif

      for (int n = 0; n < 40; n++) begin
         int k;
`ifdef MULTICYCLE_MULT_EN
         k = $urandom_range(0, 5);
`else
         k = $urandom_range(0, 4);
`endif
         case (k)
            0: doInstr(OP_LW, 6'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
            1: doInstr(OP_SW, 6'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
            2: doInstr(OP_R, rFuncts[$urandom_range(0, 6)], $urandom_range(0, 2), 0);
            3: doInstr(OP_BEQ, 6'($urandom), $urandom_range(0, 2), 0);
            4: doInstr(OP_J, 6'($urandom), $urandom_range(0, 2), 0);
            default: doInstr(OP_R, FN_MULT, $urandom_range(0, 2), 0);
         endcase
      end

      doInstr(6'b111111, 6'd0, 0, 0);
      repeat (19) applyStimulus(S_TRAP, 1'($urandom), 4'b0000);
      resetMid(1'b1, "trapAsyncReset");

      opcode = OP_LW;
      applyStimulus(S_FETCH, 1, 4'b0000);
      applyStimulus(S_DECODE, 1, 4'b0000);
      applyStimulus(S_MEM_ADDR, 1, 4'b0000);
      applyStimulus(S_MEM_RD, 0, 4'b0000);
      applyStimulus(S_MEM_RD, 0, 4'b0000);
      resetMid(1'b0, "resetInMemRd");
      doInstr(OP_LW, 6'd0, 0, 1);

      repeat (3) @(negedge clk);
      #1 checkOutput("scoreboardDrained", 24'(sbQ.size()), 24'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
